mb_bitcrush_sr: RTL

//  Parametrised bitcrusher: quantises a signed PCM stream to a run-time bit depth
//  (truncate or round/saturate) and applies sample-rate reduction by zero-order hold.

---
 rtl/mb_bitcrush_sr.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mb_bitcrush_sr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mb_bitcrush_sr                                                           |
// | Bitcrusher: run-time bit-depth quantiser with zero-order-hold rate       |
// | reduction. Optional dither enabled by MB_BITCRUSH_DITHER_EN.             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mb_bitcrush_sr #(
  parameter int WIDTH = 16,
  parameter int KB_W  = 5,
  parameter int DS_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [KB_W-1:0]  keep_bits,
  input  logic             round_en,
  input  logic [DS_W-1:0]  hold_rate,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] pcm_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] pcm_out
);

  localparam logic [KB_W-1:0]  c_width_kb = KB_W'(WIDTH);
  localparam logic [WIDTH-1:0] c_max_pos  = {1'b0, {(WIDTH-1){1'b1}}};

  logic             r_out_valid;
  logic [WIDTH-1:0] r_pcm_out;
  logic [WIDTH-1:0] r_held;
  logic [DS_W-1:0]  r_hold_cnt;

  logic [KB_W-1:0]  w_k;
  logic [31:0]      w_shift;
  logic             w_full;
  logic [WIDTH-1:0] w_lsb;
  logic [WIDTH-1:0] w_lowmask;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH:0]   w_xd;
  logic [WIDTH:0]   w_rsum;
  logic [WIDTH-1:0] w_q;

`ifdef MB_BITCRUSH_DITHER_EN
  localparam logic [15:0] c_lfsr_seed = 16'hACE1;

  logic [15:0]      r_lfsr;
  logic             w_fb;
  logic [WIDTH-1:0] w_dith;
  logic [WIDTH:0]   w_dsum;

  // Fibonacci taps for x^16+x^14+x^13+x^11+1, shifting toward bit 0
  assign w_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= c_lfsr_seed;
    end else if (in_valid && enable) begin
      r_lfsr <= {w_fb, r_lfsr[15:1]};
    end
  end
`endif

  always_comb begin
    w_k = keep_bits;
    if (keep_bits == '0) begin
      w_k = KB_W'(1);
    end else if (keep_bits > c_width_kb) begin
      w_k = c_width_kb;
    end
    w_full    = (w_k == c_width_kb);
    w_shift   = 32'(WIDTH) - 32'(w_k);
    w_lsb     = WIDTH'(1) << w_shift;
    w_lowmask = w_lsb - WIDTH'(1);
    w_mask    = ~w_lowmask;

`ifdef MB_BITCRUSH_DITHER_EN
    w_dith = w_full ? '0 : (WIDTH'(r_lfsr) & w_lowmask);
    w_dsum = {pcm_in[WIDTH-1], pcm_in} + {1'b0, w_dith};
    // Dither is non-negative, so only positive overflow is possible
    if (!w_dsum[WIDTH] && w_dsum[WIDTH-1]) begin
      w_xd = {1'b0, c_max_pos};
    end else begin
      w_xd = w_dsum;
    end
`else
    w_xd = {pcm_in[WIDTH-1], pcm_in};
`endif

    w_rsum = w_xd + {1'b0, (w_lsb >> 1)};
    if (!round_en || w_full) begin
      w_q = w_xd[WIDTH-1:0] & w_mask;
    end else if (!w_rsum[WIDTH] && w_rsum[WIDTH-1]) begin
      w_q = c_max_pos & w_mask;
    end else begin
      w_q = w_rsum[WIDTH-1:0] & w_mask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_pcm_out   <= '0;
      r_held      <= '0;
      r_hold_cnt  <= '0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        if (!enable) begin
          // Clearing the counter forces a fresh capture once crushing resumes
          r_pcm_out  <= pcm_in;
          r_hold_cnt <= '0;
        end else if (r_hold_cnt == '0) begin
          r_held     <= w_q;
          r_pcm_out  <= w_q;
          r_hold_cnt <= hold_rate;
        end else begin
          r_pcm_out  <= r_held;
          r_hold_cnt <= r_hold_cnt - DS_W'(1);
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign pcm_out   = r_pcm_out;

endmodule
`default_nettype wire
